// File: rtl/ej32_pkg.sv
// ej32_pkg: shared opcode names, prefetch FSM states and instruction-length lookup.
package ej32_pkg;

    typedef enum logic [7:0] {
        OP_NOP           = 8'h00,
        OP_BIPUSH        = 8'h10,
        OP_SIPUSH        = 8'h11,
        OP_LDC           = 8'h12,
        OP_ILOAD         = 8'h15,
        OP_ISTORE        = 8'h36,
        OP_IINC          = 8'h84,
        OP_IFEQ          = 8'h99,
        OP_GOTO          = 8'hA7,
        OP_JSR           = 8'hA8,
        OP_INVOKEVIRTUAL = 8'hB6,
        OP_INVOKESPECIAL = 8'hB7,
        OP_INVOKESTATIC  = 8'hB8,
        OP_IFNULL        = 8'hC6,
        OP_IFNONNULL     = 8'hC7,
        OP_DONEXT        = 8'hCA,
        OP_LDI           = 8'hCB,
        OP_GET           = 8'hCC,
        OP_PUT           = 8'hCD
    } opcode_t;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_REQ   = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;

    // ifeq..goto and jsr form one contiguous opcode range
    function automatic logic [1:0] ej32_op_len(input logic [7:0] op);
        return (op == OP_BIPUSH || op == OP_LDC || op == OP_ILOAD || op == OP_ISTORE ||
                (op >= OP_LDI && op <= OP_PUT)) ? 2'd2 :
               (op == OP_SIPUSH || (op >= OP_IFEQ && op <= OP_JSR) || op == OP_DONEXT ||
                op == OP_IFNULL || op == OP_IFNONNULL || op == OP_IINC ||
                (op >= OP_INVOKEVIRTUAL && op <= OP_INVOKESTATIC)) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/ej32_bqueue.sv
// ej32_bqueue: circular byte queue with a 3-byte head view, single push, pop-N and flush.
module ej32_bqueue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic [1:0]  pop,
    output logic [3:0]  cnt,
    output logic [23:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd, wr, r1, r2;

    assign r1   = rd + AW'(1);
    assign r2   = rd + AW'(2);
    assign head = {mem[r2], mem[r1], mem[rd]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= wr + AW'(1);
            end
            rd  <= rd + AW'(pop);
            cnt <= cnt + 4'(push) - 4'(pop);
        end
    end

endmodule

// File: rtl/ej32_prefetch.sv
// ej32_prefetch: bytecode prefetcher feeding the decoder from a byte queue.
// Define PREFETCH_OPLEN_EN to add the op_len/op_rdy instruction-length outputs.
module ej32_prefetch import ej32_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [3:0]  q_cnt,
    output logic [23:0] q_data,
    output logic [16:0] pc,
    input  logic [1:0]  consume,
    input  logic        jmp,
    input  logic [16:0] jmp_addr
`ifdef PREFETCH_OPLEN_EN
    ,
    output logic [1:0]  op_len,
    output logic        op_rdy
`endif
);
    fetch_state_t state;
    logic [16:0]  faddr, pend;
    logic [1:0]   pop;
    logic [4:0]   cnt_pop, cnt_nxt;
    logic         active, push;

    assign pop     = (jmp || 4'(consume) > q_cnt) ? 2'd0 : consume;
    assign cnt_pop = {1'b0, q_cnt} - 5'(pop);
    // IDLE still requests when the queue has room, so fetching starts right after reset
    assign active  = !rst && (state == ST_REQ || (state == ST_IDLE && q_cnt < 4'(DEPTH)));
    assign mem_req = active || state == ST_DRAIN;
    assign mem_addr = faddr;
    assign push    = active && mem_ack && !jmp;
    assign cnt_nxt = cnt_pop + 5'(push);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            faddr <= '0;
            pend  <= '0;
            pc    <= '0;
        end else begin
            pc   <= jmp ? jmp_addr : pc + 17'(pop);
            pend <= jmp ? jmp_addr : pend;
            if (state == ST_DRAIN) begin
                if (mem_ack) begin
                    state <= ST_REQ;
                    faddr <= jmp ? jmp_addr : pend;
                end
            end else if (jmp) begin
                state <= (active && !mem_ack) ? ST_DRAIN : ST_REQ;
                faddr <= (active && !mem_ack) ? faddr : jmp_addr;
            end else if (active) begin
                state <= (!mem_ack || cnt_nxt < 5'(DEPTH)) ? ST_REQ : ST_IDLE;
                faddr <= mem_ack ? faddr + 17'd1 : faddr;
            end else if (cnt_pop < 5'(DEPTH)) begin
                state <= ST_REQ;
            end
        end
    end

    ej32_bqueue #(.DEPTH(DEPTH)) u_queue (
        .clk  (clk),
        .rst  (rst),
        .flush(jmp),
        .push (push),
        .din  (mem_data),
        .pop  (pop),
        .cnt  (q_cnt),
        .head (q_data)
    );

`ifdef PREFETCH_OPLEN_EN
    assign op_len = ej32_op_len(q_data[7:0]);
    assign op_rdy = q_cnt >= 4'(op_len);
`endif

endmodule

// File: tb/tb_ej32_prefetch.sv
// tb_ej32_prefetch: directed self-checking bench for ej32_prefetch with a zero-latency memory model.
module tb_ej32_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_ack, ack_en = 1'b1, jmp = 1'b0;
    logic [16:0] mem_addr, pc, jmp_addr = '0;
    logic [7:0]  mem_data;
    logic [3:0]  q_cnt;
    logic [23:0] q_data;
    logic [1:0]  consume = 2'd0;
`ifdef PREFETCH_OPLEN_EN
    logic [1:0]  op_len;
    logic        op_rdy;
`endif
    int checks = 0;
    int fails  = 0;

    localparam logic [7:0] ROM [8] = '{8'h10, 8'h2A, 8'h60, 8'h11, 8'h00, 8'h05, 8'h60, 8'h3C};
    localparam logic [16:0] WRAP [4] = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};

    always #5 clk = ~clk;

    always_comb begin
        mem_data = (mem_addr < 17'd8) ? ROM[mem_addr[2:0]] : mem_addr[7:0] ^ 8'hA5;
        mem_ack  = mem_req && ack_en;
    end

    ej32_prefetch #(.DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_req (mem_req),
        .mem_addr(mem_addr),
        .mem_ack (mem_ack),
        .mem_data(mem_data),
        .q_cnt   (q_cnt),
        .q_data  (q_data),
        .pc      (pc),
        .consume (consume),
        .jmp     (jmp),
        .jmp_addr(jmp_addr)
`ifdef PREFETCH_OPLEN_EN
        ,
        .op_len  (op_len),
        .op_rdy  (op_rdy)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_cnt", 32'(q_cnt), 0);
        chk("rst_data", 32'(q_data), 0);
        chk("rst_pc", 32'(pc), 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_req%0d", i), 32'(mem_req), 1);
            chk($sformatf("fill_addr%0d", i), 32'(mem_addr), 32'(i));
            step();
        end
        chk("full_req", 32'(mem_req), 0);
        chk("full_cnt", 32'(q_cnt), 8);
        chk("full_data", 32'(q_data), 32'h602A10);
        chk("full_pc", 32'(pc), 0);

        consume = 2'd2;
        #1;
        chk("pop_noreq", 32'(mem_req), 0);
        step();
        consume = 2'd0;
        ack_en  = 1'b0;
        #1;
        chk("pop_pc", 32'(pc), 2);
        chk("pop_cnt", 32'(q_cnt), 6);
        chk("pop_head", 32'(q_data[7:0]), 32'h60);
        chk("refetch_req", 32'(mem_req), 1);
        chk("refetch_addr", 32'(mem_addr), 8);

        jmp      = 1'b1;
        jmp_addr = 17'h00100;
        step();
        jmp = 1'b0;
        #1;
        chk("jmp_pc", 32'(pc), 32'h100);
        chk("jmp_cnt", 32'(q_cnt), 0);
        chk("drain_req", 32'(mem_req), 1);
        chk("drain_addr0", 32'(mem_addr), 8);
        step();
        chk("drain_addr1", 32'(mem_addr), 8);
        step();
        chk("drain_addr2", 32'(mem_addr), 8);
        ack_en = 1'b1;
        step();
        chk("drop_cnt", 32'(q_cnt), 0);
        chk("redir_addr", 32'(mem_addr), 32'h100);
        chk("redir_req", 32'(mem_req), 1);
        step();
        ack_en = 1'b0;
        #1;
        chk("redir_cnt", 32'(q_cnt), 1);
        chk("redir_pc", 32'(pc), 32'h100);
        chk("redir_head", 32'(q_data[7:0]), 32'hA5);

        consume = 2'd3;
        step();
        consume = 2'd0;
        chk("over_pc", 32'(pc), 32'h100);
        chk("over_cnt", 32'(q_cnt), 1);

        jmp      = 1'b1;
        jmp_addr = 17'h1FFFE;
        ack_en   = 1'b1;
        step();
        jmp = 1'b0;
        #1;
        chk("jack_cnt", 32'(q_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_addr%0d", i), 32'(mem_addr), 32'(WRAP[i]));
            step();
        end
        chk("wrap_cnt", 32'(q_cnt), 4);
        chk("wrap_pc", 32'(pc), 32'h1FFFE);
        consume = 2'd3;
        step();
        consume = 2'd0;
        chk("pcwrap_pc", 32'(pc), 1);
        chk("pushpop_cnt", 32'(q_cnt), 2);
        chk("pcwrap_head", 32'(q_data[7:0]), 32'h2A);

        jmp      = 1'b1;
        jmp_addr = 17'd3;
        step();
        jmp = 1'b0;
        step();
        step();
        ack_en = 1'b0;
        #1;
        chk("op2_cnt", 32'(q_cnt), 2);
        chk("op2_head", 32'(q_data[7:0]), 32'h11);
`ifdef PREFETCH_OPLEN_EN
        chk("sipush_len", 32'(op_len), 3);
        chk("sipush_rdy2", 32'(op_rdy), 0);
`endif
        ack_en = 1'b1;
        step();
        ack_en = 1'b0;
        #1;
        chk("op3_cnt", 32'(q_cnt), 3);
`ifdef PREFETCH_OPLEN_EN
        chk("sipush_rdy3", 32'(op_rdy), 1);
`endif
        ack_en = 1'b1;
        step();
        ack_en  = 1'b0;
        consume = 2'd3;
        step();
        consume = 2'd0;
        chk("op1_cnt", 32'(q_cnt), 1);
        chk("op1_head", 32'(q_data[7:0]), 32'h60);
`ifdef PREFETCH_OPLEN_EN
        chk("iadd_len", 32'(op_len), 1);
        chk("iadd_rdy", 32'(op_rdy), 1);
`endif

        chk("mid_req", 32'(mem_req), 1);
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 0);
        chk("arst_addr", 32'(mem_addr), 0);
        chk("arst_cnt", 32'(q_cnt), 0);
        chk("arst_pc", 32'(pc), 0);
        step();
        rst    = 1'b0;
        ack_en = 1'b1;
        #1;
        chk("post_req", 32'(mem_req), 1);
        chk("post_addr", 32'(mem_addr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/ej32_prefetch.md
EJ32_PREFETCH -- requirements
Module: ej32_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning byte-queue depth (power of two, at least 4).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port mem_req  output  1  fetch request to bytecode memory.
REQ-005 SHALL have port mem_addr  output  17  byte address of the request.
REQ-006 SHALL have port mem_ack  input  1  request accepted; mem_data valid in the same cycle.
REQ-007 SHALL have port mem_data  input  8  fetched byte.
REQ-008 SHALL have port q_cnt  output  4  number of valid bytes in the queue (0..DEPTH).
REQ-009 SHALL have port q_data  output  24  queue head bytes: [7:0] is the opcode byte, [15:8] is operand 1, [23:16] is operand 2; bytes beyond q_cnt are don't-care.
REQ-010 SHALL have port pc  output  17  address of the byte in q_data[7:0].
REQ-011 SHALL have port consume  input  2  number of bytes the decoder pops this cycle (0..3).
REQ-012 SHALL have port jmp  input  1  redirect strobe.
REQ-013 SHALL have port jmp_addr  input  17  redirect target.

Function
REQ-014 SHALL implement a fetch FSM with states IDLE, REQ and DRAIN.
REQ-015 SHALL move IDLE->REQ when free slots (DEPTH - q_cnt) exceed 0 after this cycle's pop.
REQ-016 SHALL, in REQ, hold mem_req=1 and mem_addr stable until mem_ack; one outstanding request maximum.
REQ-017 SHALL, on mem_ack in REQ, write mem_data into the queue and increment the fetch address.
REQ-018 SHALL, after that ack, go to REQ again if space remains, else to IDLE; back-to-back requests give 1 byte per cycle.
REQ-019 SHALL make a written byte visible in q_cnt/q_data the cycle after mem_ack; consume takes effect the cycle after it is asserted, and pc advances by consume.
REQ-020 SHALL ignore consume entirely when consume > q_cnt: no pop and no pc change.
REQ-021 SHALL allow a push and a pop in the same cycle; q_cnt then changes by (push - consume).
REQ-022 SHALL, on jmp, in the next cycle: empty the queue (q_cnt=0), set pc=jmp_addr and set fetch address=jmp_addr.
REQ-023 SHALL take jmp priority over consume and over a same-cycle mem_ack, whose byte is discarded.
REQ-024 SHALL, when jmp arrives in REQ with no ack, enter DRAIN: keep mem_req and the old mem_addr until mem_ack, discard that byte, then go to REQ at the new address.
REQ-025 SHALL wrap the fetch address and pc modulo 2^17 (0x1FFFF+1 -> 0x00000).
REQ-026 SHALL never overflow the queue: no request is issued when it is full.

Reset
REQ-027 SHALL, while rst is high, force: state=IDLE, mem_req=0, mem_addr=0, pc=0, q_cnt=0, q_data=0.
REQ-028 SHALL, on rst asserted mid-request, abandon the request without waiting for mem_ack.
REQ-029 SHALL assert mem_req in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with PREFETCH_OPLEN_EN defined, add outputs op_len (2 bits, total instruction bytes 1..3) and op_rdy (1 = q_cnt >= op_len), decoded from q_data[7:0].
REQ-031 SHALL, with PREFETCH_OPLEN_EN defined, decode: bipush, ldc, iload, istore, and the ldi/get/put family that take an 8-bit operand = 2; sipush, branches (ifeq..goto, jsr, donext, ifnull, ifnonnull), invokevirtual/static/special and iinc = 3; all others = 1.
REQ-032 SHALL, without PREFETCH_OPLEN_EN, omit those ports and logic; queue behaviour is identical either way.

Structure
REQ-033 SHALL place the FSM state enum and the op_len lookup function in the shared ej32 package, alongside opcode_t.
REQ-034 SHALL implement the queue as a sub-module ej32_bqueue: circular buffer with 3-byte head view, push, pop-N and flush.

Verification
REQ-035 SHALL verify: reset, memory returns 0x10,0x2A,0x60,... with immediate ack -> mem_addr 0..7 in consecutive cycles, then mem_req=0 at q_cnt=8, q_data=0x602A10, pc=0.
REQ-036 SHALL verify: from full, consume=2 -> next cycle pc=2, q_cnt=6, q_data[7:0]=0x60; refetch begins at address 8.
REQ-037 SHALL verify: jmp with jmp_addr=0x00100 while in REQ with mem_ack withheld 3 cycles -> DRAIN holds the old addr; the acked byte is dropped; the next request goes to 0x00100; pc=0x00100, q_cnt=0.
REQ-038 SHALL verify: q_cnt=1, consume=3 -> ignored; pc and q_cnt unchanged.
REQ-039 SHALL verify: jmp_addr=0x1FFFE, fetch 4 bytes -> mem_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
REQ-040 SHALL verify, with PREFETCH_OPLEN_EN: head 0x11 (sipush) with q_cnt=2 -> op_len=3, op_rdy=0; q_cnt=3 -> op_rdy=1; head 0x60 -> op_len=1.
